// File: rtl/rv32_dmem_watch_if.sv
// Data-memory bus for rv32_dmem_watch: core load/store port plus the store-watch
// drain handshake. The master side is the core or bench; the slave is the memory.
interface rv32_dmem_watch_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      dmemaddr;
    logic [31:0]      dmemdatain;
    logic [2:0]       dmemop;
    logic             dmemre;
    logic             dmemwe;
    logic [31:0]      dmemdataout;
    logic             misalign;
    logic             clear;
    logic             watch_valid;
    logic [31:0]      watch_data;
    logic             watch_ready;
    logic [CNT_W-1:0] watch_count;
    logic             watch_overflow;

    modport master (
        output dmemaddr, dmemdatain, dmemop, dmemre, dmemwe, clear, watch_ready,
        input  dmemdataout, misalign, watch_valid, watch_data, watch_count, watch_overflow
    );

    modport slave (
        input  dmemaddr, dmemdatain, dmemop, dmemre, dmemwe, clear, watch_ready,
        output dmemdataout, misalign, watch_valid, watch_data, watch_count, watch_overflow
    );
endinterface

// File: rtl/rv32_dmem_watch.sv
// RV32I data memory with byte/half/word access and a FIFO that traces every legal
// store to the watched word. The interface FIFO_DEPTH must match this module's.
module rv32_dmem_watch #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] WATCH_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    rv32_dmem_watch_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [WORDS];
    logic [31:0]           r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_misalign;
    logic [31:0]           r_dout;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic                  w_ld_legal;
    logic                  w_st_legal;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_push_data;
    logic [31:0]           w_rd_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ld_val;
    logic                  w_st_fire;
    logic                  w_hit;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_bad;

    assign w_idx  = bus.dmemaddr[ADDR_WIDTH+1:2];
    assign w_lane = bus.dmemaddr[1:0];

    // Alignment and opcode legality for the current load and store
    always_comb begin
        w_ld_legal = 1'b0;
        w_st_legal = 1'b0;
        case (bus.dmemop)
            3'b000:  begin w_ld_legal = 1'b1;            w_st_legal = 1'b1;            end
            3'b001:  begin w_ld_legal = ~w_lane[0];      w_st_legal = ~w_lane[0];      end
            3'b010:  begin w_ld_legal = (w_lane == 2'b00); w_st_legal = (w_lane == 2'b00); end
            3'b100:  w_ld_legal = 1'b1;
            3'b101:  w_ld_legal = ~w_lane[0];
            default: begin w_ld_legal = 1'b0;            w_st_legal = 1'b0;            end
        endcase
    end

    // Store byte enables, lane-replicated write data and the zero-extended trace value
    always_comb begin
        w_be        = 4'b0000;
        w_wdata     = 32'h0000_0000;
        w_push_data = 32'h0000_0000;
        case (bus.dmemop)
            3'b000: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata     = {4{bus.dmemdatain[7:0]}};
                w_push_data = {24'h00_0000, bus.dmemdatain[7:0]};
            end
            3'b001: begin
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata     = {2{bus.dmemdatain[15:0]}};
                w_push_data = {16'h0000, bus.dmemdatain[15:0]};
            end
            3'b010: begin
                w_be        = 4'b1111;
                w_wdata     = bus.dmemdatain;
                w_push_data = bus.dmemdatain;
            end
            default: begin
                w_be        = 4'b0000;
                w_wdata     = 32'h0000_0000;
                w_push_data = 32'h0000_0000;
            end
        endcase
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[{w_lane, 3'b000} +: 8];
    assign w_half    = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Lane extraction and extension; illegal loads read as zero
    always_comb begin
        w_ld_val = 32'h0000_0000;
        case (bus.dmemop)
            3'b000:  w_ld_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_val = {24'h00_0000, w_byte};
            3'b001:  w_ld_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_val = {16'h0000, w_half};
            3'b010:  w_ld_val = w_rd_word;
            default: w_ld_val = 32'h0000_0000;
        endcase
        if (!w_ld_legal) begin
            w_ld_val = 32'h0000_0000;
        end else begin
            w_ld_val = w_ld_val;
        end
    end

    assign w_st_fire = bus.dmemwe & w_st_legal;
    assign w_hit     = w_st_fire & (bus.dmemaddr[31:2] == WATCH_ADDR[31:2]);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = (r_count != {CNT_W{1'b0}}) & bus.watch_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push    = w_hit & (~w_full | w_pop);
    assign w_drop    = w_hit & w_full & ~w_pop;
    assign w_bad     = (bus.dmemre & ~w_ld_legal) | (bus.dmemwe & ~w_st_legal);

    // Memory array write; contents survive reset
    always_ff @(posedge clock) begin
        if (w_st_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Watch FIFO storage
    always_ff @(posedge clock) begin
        if (!bus.clear && w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers, occupancy and sticky flags; clear outranks push and pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
            if (w_bad)  r_misalign <= 1'b1;
        end
    end

    // Registered load result, held between loads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dout <= 32'h0000_0000;
        end else if (bus.dmemre) begin
            r_dout <= w_ld_val;
        end else begin
            r_dout <= r_dout;
        end
    end

    assign bus.dmemdataout    = r_dout;
    assign bus.misalign       = r_misalign;
    assign bus.watch_valid    = (r_count != {CNT_W{1'b0}});
    assign bus.watch_data     = r_fifo[r_rd_ptr];
    assign bus.watch_count    = r_count;
    assign bus.watch_overflow = r_overflow;
endmodule
